reg_file_p: RTL and testbench

Parametrised register file for the downsampling datapath. It provides two combinational read buses (A, B), one synchronous write bus (C), and dedicated DMAR/DMDR slots (indices 0 and 1) that drive the data-memory address and write data. A built-in load engine performs handshaked data-memory reads into DMDR, with optional DMAR post-increment and a timeout. Every register is cleared by a synchronous global reset or by a single-register clear.

---
 rtl/reg_file_p_if.sv | 28 ++
 rtl/reg_file_p.sv | 131 +++++++++++++
 tb/tb_reg_file_p.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_p_if.sv
// Data-memory side of the register file: load handshake plus the DMAR/DMDR
// address and write-data buses.
interface reg_file_p_if #(
    parameter int DATA_W = 19,
    parameter int MEM_W  = 8
);
    logic              mem_rd;
    logic              mem_valid;
    logic [MEM_W-1:0]  mem_data;
    logic [DATA_W-1:0] dm_addr;
    logic [MEM_W-1:0]  dm_data;

    modport master (
        output mem_rd,
        output dm_addr,
        output dm_data,
        input  mem_valid,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  dm_addr,
        input  dm_data,
        output mem_valid,
        output mem_data
    );
endinterface

// File: rtl/reg_file_p.sv
// Register file with two combinational read buses, one write bus, DMAR/DMDR
// slots and a handshaked data-memory load engine with timeout.
module reg_file_p #(
    parameter int DATA_W   = 19,
    parameter int MEM_W    = 8,
    parameter int NUM_REGS = 14,
    parameter int SEL_W    = 4,
    parameter int BYPASS   = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic              CLR,
    input  logic [SEL_W-1:0]  CLR_SEL,
    input  logic              C_EN,
    input  logic [SEL_W-1:0]  C_SEL,
    input  logic [DATA_W-1:0] c_in,
    input  logic [SEL_W-1:0]  A_SEL,
    input  logic [SEL_W-1:0]  B_SEL,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    input  logic              MEM_REQ,
    input  logic              AUTO_INC,
    output logic              busy,
    output logic              load_done,
    output logic              mem_err,
    reg_file_p_if.master      mem
);
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SEL_W:0]    NREG     = (SEL_W + 1)'(NUM_REGS);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [CNT_W-1:0]    cnt;
    logic                inc_flag;
    logic                mem_rd_q;
    logic                capture;
    logic                timed_out;
    logic [NUM_REGS-1:0] clr_hit;
    logic [NUM_REGS-1:0] eng_hit;
    logic [NUM_REGS-1:0] c_hit;
    logic                fwd;

    assign capture   = (state == WAIT) && mem.mem_valid;
    assign timed_out = (TIMEOUT != 0) && (state == WAIT) && !mem.mem_valid && (cnt == CNT_LAST);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            clr_hit[i] = CLR && (CLR_SEL == SEL_W'(i));
            c_hit[i]   = C_EN && (C_SEL == SEL_W'(i));
            eng_hit[i] = 1'b0;
        end
        eng_hit[0] = capture && inc_flag;
        eng_hit[1] = capture;
    end

    // Each register resolves its own writer: clear beats the load engine beats the C bus.
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_hit[i])
                    regs[i] <= '0;
                else if (eng_hit[i])
                    regs[i] <= (i == 0) ? regs[0] + 1'b1 : DATA_W'(mem.mem_data);
                else if (c_hit[i])
                    regs[i] <= c_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            inc_flag  <= 1'b0;
            mem_rd_q  <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (MEM_REQ) begin
                        state    <= WAIT;
                        inc_flag <= AUTO_INC;
                        cnt      <= '0;
                        mem_rd_q <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (capture) begin
                        state     <= IDLE;
                        mem_rd_q  <= 1'b0;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                    end else if (timed_out) begin
                        state    <= IDLE;
                        mem_rd_q <= 1'b0;
                        busy     <= 1'b0;
                        mem_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A C write is only forwarded when it is the write that will actually land.
    assign fwd = (BYPASS != 0) && (|(c_hit & ~(clr_hit | eng_hit)));

    always_comb begin
        a_out = '0;
        b_out = '0;
        if ({1'b0, A_SEL} < NREG) a_out = (fwd && (A_SEL == C_SEL)) ? c_in : regs[A_SEL];
        if ({1'b0, B_SEL} < NREG) b_out = (fwd && (B_SEL == C_SEL)) ? c_in : regs[B_SEL];
    end

    assign mem.mem_rd  = mem_rd_q;
    assign mem.dm_addr = regs[0];
    assign mem.dm_data = regs[1][MEM_W-1:0];
endmodule

// File: tb/tb_reg_file_p.sv
// Scoreboard bench for reg_file_p: register writes/reads, bypass, loads with
// post-increment, timeout, write priority and reset during a load.
module tb_reg_file_p;
    localparam int DATA_W   = 19;
    localparam int MEM_W    = 8;
    localparam int NUM_REGS = 14;
    localparam int SEL_W    = 4;
    localparam int TIMEOUT  = 4;

    logic              clk = 1'b0;
    logic              RST_N;
    logic              CLR;
    logic [SEL_W-1:0]  CLR_SEL;
    logic              C_EN;
    logic [SEL_W-1:0]  C_SEL;
    logic [DATA_W-1:0] c_in;
    logic [SEL_W-1:0]  A_SEL;
    logic [SEL_W-1:0]  B_SEL;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic              MEM_REQ;
    logic              AUTO_INC;
    logic              busy;
    logic              load_done;
    logic              mem_err;

    reg_file_p_if #(.DATA_W(DATA_W), .MEM_W(MEM_W)) mif ();

    reg_file_p #(
        .DATA_W(DATA_W), .MEM_W(MEM_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
        .BYPASS(1), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .RST_N(RST_N), .CLR(CLR), .CLR_SEL(CLR_SEL),
        .C_EN(C_EN), .C_SEL(C_SEL), .c_in(c_in),
        .A_SEL(A_SEL), .B_SEL(B_SEL), .a_out(a_out), .b_out(b_out),
        .MEM_REQ(MEM_REQ), .AUTO_INC(AUTO_INC),
        .busy(busy), .load_done(load_done), .mem_err(mem_err),
        .mem(mif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] model [NUM_REGS];
    int                checks = 0;
    int                errors = 0;
    int                rd;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic expectVal(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic popCheck(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got 0x%0h expected nothing", obs);
        end else begin
            e = exp_q.pop_front();
            checkOutput(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] val);
        C_EN  = 1'b1;
        C_SEL = sel;
        c_in  = val;
        tick();
        C_EN  = 1'b0;
        if (int'(sel) < NUM_REGS) model[sel] = val;
    endtask

    task automatic readCheck(input logic [SEL_W-1:0] sa, input logic [SEL_W-1:0] sb, input string tag);
        logic [31:0] ea;
        logic [31:0] eb;
        A_SEL = sa;
        B_SEL = sb;
        ea = 32'd0;
        eb = 32'd0;
        if (int'(sa) < NUM_REGS) ea = 32'(model[sa]);
        if (int'(sb) < NUM_REGS) eb = 32'(model[sb]);
        expectVal({tag, "_a"}, ea);
        expectVal({tag, "_b"}, eb);
        #1;
        popCheck(32'(a_out));
        popCheck(32'(b_out));
    endtask

    // side 1: C write to DMDR plus clear of DMAR on the capture edge; side 2: clear of DMDR.
    task automatic doLoad(input logic ai, input int delay, input logic [MEM_W-1:0] data,
                          input int side, output int rd_cycles);
        MEM_REQ  = 1'b1;
        AUTO_INC = ai;
        tick();
        MEM_REQ  = 1'b0;
        AUTO_INC = 1'b0;
        rd_cycles = 0;
        for (int n = 0; n < delay; n++) begin
            if (mif.mem_rd) rd_cycles++;
            if (n == delay - 1) begin
                mif.mem_valid = 1'b1;
                mif.mem_data  = data;
                if (side == 1) begin
                    C_EN = 1'b1; C_SEL = 4'd1; c_in = 19'h00055;
                    CLR = 1'b1; CLR_SEL = 4'd0; A_SEL = 4'd1;
                    #1;
                    checkOutput("bypass_eng_suppress", 32'(a_out), 32'(model[1]));
                end
                if (side == 2) begin
                    CLR = 1'b1; CLR_SEL = 4'd1;
                end
            end
            tick();
        end
        mif.mem_valid = 1'b0;
        C_EN = 1'b0;
        CLR  = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; CLR = 1'b0; CLR_SEL = '0; C_EN = 1'b0; C_SEL = '0; c_in = '0;
        A_SEL = '0; B_SEL = '0; MEM_REQ = 1'b0; AUTO_INC = 1'b0;
        mif.mem_valid = 1'b0; mif.mem_data = '0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_mem_rd", 32'(mif.mem_rd), 0);
        checkOutput("rst_load_done", 32'(load_done), 0);
        checkOutput("rst_mem_err", 32'(mem_err), 0);
        checkOutput("rst_dm_addr", 32'(mif.dm_addr), 0);

        for (int i = 0; i < NUM_REGS; i++) applyStimulus(SEL_W'(i), DATA_W'(i * 32'h1111 + 1));
        for (int i = 0; i < NUM_REGS; i++) readCheck(SEL_W'(i), SEL_W'(NUM_REGS - 1 - i), "preload");

        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        for (int i = 0; i < NUM_REGS; i++) readCheck(SEL_W'(i), SEL_W'(NUM_REGS - 1 - i), "after_rst");
        checkOutput("after_rst_dm_addr", 32'(mif.dm_addr), 0);
        checkOutput("after_rst_dm_data", 32'(mif.dm_data), 0);
        checkOutput("after_rst_busy", 32'(busy), 0);

        A_SEL = 4'd5; C_EN = 1'b1; C_SEL = 4'd5; c_in = 19'h01234;
        #1;
        checkOutput("bypass_same_cycle", 32'(a_out), 32'h1234);
        tick();
        C_EN = 1'b0;
        model[5] = 19'h01234;
        readCheck(4'd5, 4'd0, "write5");

        applyStimulus(4'd14, 19'h07ABC);
        for (int i = 0; i < NUM_REGS; i++) readCheck(SEL_W'(i), 4'd14, "oor_write");

        applyStimulus(4'd6, 19'h00222);
        A_SEL = 4'd6; C_EN = 1'b1; C_SEL = 4'd6; c_in = 19'h00333; CLR = 1'b1; CLR_SEL = 4'd6;
        #1;
        checkOutput("bypass_clr_suppress", 32'(a_out), 32'h222);
        tick();
        C_EN = 1'b0; CLR = 1'b0;
        model[6] = '0;
        readCheck(4'd6, 4'd5, "clr_wins");
        CLR = 1'b1; CLR_SEL = 4'd15;
        tick();
        CLR = 1'b0;
        readCheck(4'd5, 4'd0, "oor_clr");

        applyStimulus(4'd0, 19'h7FFFF);
        expectVal("ld_inc_dmdr", 32'h000A5);
        expectVal("ld_inc_dmar", 32'h00000);
        doLoad(1'b1, 3, 8'hA5, 0, rd);
        checkOutput("ld_done_pulse", 32'(load_done), 1);
        checkOutput("ld_busy_low", 32'(busy), 0);
        checkOutput("ld_mem_rd_low", 32'(mif.mem_rd), 0);
        checkOutput("ld_rd_cycles", 32'(rd), 3);
        popCheck(32'(mif.dm_data));
        popCheck(32'(mif.dm_addr));
        model[1] = 19'h000A5;
        model[0] = '0;
        readCheck(4'd1, 4'd0, "ld_inc_regs");

        MEM_REQ = 1'b1; AUTO_INC = 1'b1;
        tick();
        MEM_REQ = 1'b0; AUTO_INC = 1'b0;
        checkOutput("ld_done_clear", 32'(load_done), 0);
        checkOutput("b2b_accept", 32'(busy), 1);
        rd = 0;
        for (int n = 0; n < 12 && busy; n++) begin
            if (mif.mem_rd) rd++;
            tick();
        end
        checkOutput("to_bound", 32'(busy), 0);
        checkOutput("to_rd_cycles", 32'(rd), TIMEOUT);
        checkOutput("to_mem_err", 32'(mem_err), 1);
        checkOutput("to_no_done", 32'(load_done), 0);
        checkOutput("to_dm_addr", 32'(mif.dm_addr), 32'(model[0]));
        checkOutput("to_dm_data", 32'(mif.dm_data), 32'hA5);
        mif.mem_valid = 1'b1; mif.mem_data = 8'h3C;
        tick();
        mif.mem_valid = 1'b0;
        checkOutput("late_valid_err", 32'(mem_err), 0);
        checkOutput("late_valid_done", 32'(load_done), 0);
        checkOutput("late_valid_busy", 32'(busy), 0);
        checkOutput("late_valid_dm_data", 32'(mif.dm_data), 32'hA5);

        applyStimulus(4'd0, 19'h00010);
        expectVal("prio_dmdr", 32'h0005A);
        expectVal("prio_dmar", 32'h00000);
        doLoad(1'b1, 2, 8'h5A, 1, rd);
        checkOutput("prio_done", 32'(load_done), 1);
        checkOutput("prio_rd_cycles", 32'(rd), 2);
        A_SEL = 4'd1; B_SEL = 4'd0;
        #1;
        popCheck(32'(a_out));
        popCheck(32'(b_out));
        model[1] = 19'h0005A;
        model[0] = '0;

        applyStimulus(4'd0, 19'h00020);
        expectVal("clr_dmdr", 32'h0);
        doLoad(1'b0, 1, 8'h99, 2, rd);
        checkOutput("clr_dmdr_done", 32'(load_done), 1);
        A_SEL = 4'd1;
        #1;
        popCheck(32'(a_out));
        checkOutput("clr_dmdr_dmar", 32'(mif.dm_addr), 32'h20);
        model[1] = '0;

        MEM_REQ = 1'b1;
        tick();
        MEM_REQ = 1'b0;
        checkOutput("rstwait_busy_before", 32'(busy), 1);
        tick();
        RST_N = 1'b0; mif.mem_valid = 1'b1; mif.mem_data = 8'h77;
        tick();
        RST_N = 1'b1; mif.mem_valid = 1'b0;
        checkOutput("rstwait_busy", 32'(busy), 0);
        checkOutput("rstwait_mem_rd", 32'(mif.mem_rd), 0);
        checkOutput("rstwait_done", 32'(load_done), 0);
        checkOutput("rstwait_err", 32'(mem_err), 0);
        checkOutput("rstwait_dm_data", 32'(mif.dm_data), 0);
        mif.mem_valid = 1'b1;
        tick();
        mif.mem_valid = 1'b0;
        checkOutput("rstwait_late_done", 32'(load_done), 0);
        checkOutput("rstwait_late_dm_data", 32'(mif.dm_data), 0);
        checkOutput("rstwait_late_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
